// File: rtl/decim_multi.sv
// ---------------------------------------------------------------------------
// decim_multi
//   Multi-channel decimator for the sonar sample path. Takes a time-interleaved
//   AXI-Stream (channel index on tuser) and emits one beat per R accepted
//   beats of each channel. It has two modes:
//     cfg_mode = 0 : pick, which keeps the first sample of each group.
//     cfg_mode = 1 : accumulate-and-dump, which outputs the group sum shifted
//                    right by cfg_shift and saturated to DATA_W.
//   The output is a single register stage, so nothing on the master side
//   depends combinationally on tuser or tdata.
//
// Ports
//   s_axis_aclk, s_axis_aresetn        clock, async active-low reset
//   cfg_ratio, cfg_mode, cfg_shift     decimation ratio R, mode, dump shift
//   cfg_flush                          clear all per-channel state
//   s_axis_t{data,valid,ready,user,last}  input stream (tuser = channel)
//   m_axis_t{data,valid,ready,user,last}  decimated output stream
// ---------------------------------------------------------------------------
module decim_multi #(
  parameter int DATA_W    = 24,
  parameter int CH_W      = 3,
  parameter int MAX_RATIO = 16,
  parameter int RATIO_W   = 5,
  parameter int ACC_W     = DATA_W + $clog2(MAX_RATIO),
  localparam int SH_W     = $clog2(ACC_W)
) (
  input  logic                s_axis_aclk,
  input  logic                s_axis_aresetn,
  input  logic [RATIO_W-1:0]  cfg_ratio,
  input  logic                cfg_mode,
  input  logic [SH_W-1:0]     cfg_shift,
  input  logic                cfg_flush,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic [CH_W-1:0]     s_axis_tuser,
  input  logic                s_axis_tlast,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [CH_W-1:0]     m_axis_tuser,
  output logic                m_axis_tlast
);

  localparam int NCH   = 2 ** CH_W;
  localparam int CNT_W = (MAX_RATIO > 1) ? $clog2(MAX_RATIO) : 1;

  logic [CNT_W-1:0]        cnt   [NCH];
  logic signed [ACC_W-1:0] acc   [NCH];
  logic                    lastf [NCH];

  logic                    accept;
  logic [RATIO_W-1:0]      r_eff;
  logic [RATIO_W-1:0]      r_m1;
  logic [CNT_W-1:0]        cnt_cur;
  logic                    wrap;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic [ACC_W-DATA_W:0]   upper;
  logic [DATA_W-1:0]       sat;
  logic                    emit;
  logic [DATA_W-1:0]       out_data;
  logic                    out_last;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    r_eff    = cfg_ratio;
    r_m1     = '0;
    cnt_cur  = '0;
    wrap     = 1'b0;
    sum      = '0;
    shifted  = '0;
    upper    = '0;
    sat      = '0;
    emit     = 1'b0;
    out_data = '0;
    out_last = 1'b0;

    if (cfg_ratio == '0)
      r_eff = RATIO_W'(1);
    else if (cfg_ratio > RATIO_W'(MAX_RATIO))
      r_eff = RATIO_W'(MAX_RATIO);
    r_m1 = r_eff - 1'b1;

    cnt_cur = cnt[s_axis_tuser];
    // A counter left above a freshly lowered ratio also wraps here.
    wrap    = (RATIO_W'(cnt_cur) >= r_m1);

    sum     = acc[s_axis_tuser] + {{(ACC_W-DATA_W){s_axis_tdata[DATA_W-1]}}, s_axis_tdata};
    shifted = sum >>> cfg_shift;

    // The value fits DATA_W when every bit from the DATA_W sign bit upward
    // agrees; otherwise clamp toward the sign of the full-width result.
    upper = shifted[ACC_W-1:DATA_W-1];
    if (upper == '0 || upper == '1)
      sat = shifted[DATA_W-1:0];
    else if (shifted[ACC_W-1])
      sat = {1'b1, {(DATA_W-1){1'b0}}};
    else
      sat = {1'b0, {(DATA_W-1){1'b1}}};

    if (cfg_mode) begin
      emit     = wrap;
      out_data = sat;
    end else begin
      emit     = (cnt_cur == '0);
      out_data = s_axis_tdata;
    end
    out_last = lastf[s_axis_tuser] | s_axis_tlast;
  end

  // Per-channel state. Flush beats any same-cycle accept.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]   <= '0;
        acc[i]   <= '0;
        lastf[i] <= 1'b0;
      end
    end else if (cfg_flush) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]   <= '0;
        acc[i]   <= '0;
        lastf[i] <= 1'b0;
      end
    end else if (accept) begin
      cnt[s_axis_tuser]   <= wrap ? '0 : cnt_cur + 1'b1;
      lastf[s_axis_tuser] <= emit ? 1'b0 : out_last;
      if (cfg_mode)
        acc[s_axis_tuser] <= wrap ? '0 : sum;
    end
  end

  // Output register: load on an emitting accept, otherwise drain on ready.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (accept && emit && !cfg_flush) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= out_data;
      m_axis_tuser  <= s_axis_tuser;
      m_axis_tlast  <= out_last;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decim_multi.sv
module tb_decim_multi;

  localparam int DATA_W = 24;
  localparam int CH_W   = 3;

  logic              clk;
  logic              rst_n;
  logic [4:0]        cfg_ratio;
  logic              cfg_mode;
  logic [4:0]        cfg_shift;
  logic              cfg_flush;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic [CH_W-1:0]   s_tuser;
  logic              s_tlast;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic [CH_W-1:0]   m_tuser;
  logic              m_tlast;

  decim_multi dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .cfg_ratio      (cfg_ratio),
    .cfg_mode       (cfg_mode),
    .cfg_shift      (cfg_shift),
    .cfg_flush      (cfg_flush),
    .s_axis_tdata   (s_tdata),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .s_axis_tuser   (s_tuser),
    .s_axis_tlast   (s_tlast),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .m_axis_tuser   (m_tuser),
    .m_axis_tlast   (m_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [CH_W-1:0]   u;
    logic              l;
  } exp_t;

  exp_t   sb[$];
  exp_t   e;
  int     n_checks = 0;
  int     n_errors = 0;
  bit     rnd_rdy  = 0;

  int     m_cnt  [8];
  longint m_acc  [8];
  bit     m_last [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_cnt[i]  = 0;
      m_acc[i]  = 0;
      m_last[i] = 0;
    end
  endtask

  task automatic model(input int ch, input logic [DATA_W-1:0] d, input bit l);
    int     re;
    bit     emit;
    bit     lt;
    longint sd;
    longint v;
    exp_t   x;
    re = (cfg_ratio == 0) ? 1 : (cfg_ratio > 16) ? 16 : int'(cfg_ratio);
    sd = longint'($signed(d));
    emit = 0;
    v = 0;
    if (!cfg_mode) begin
      emit = (m_cnt[ch] == 0);
      v = sd;
    end else if (m_cnt[ch] >= re - 1) begin
      emit = 1;
      v = (m_acc[ch] + sd) >>> cfg_shift;
      if (v > 64'sd8388607)  v = 64'sd8388607;
      if (v < -64'sd8388608) v = -64'sd8388608;
      m_acc[ch] = 0;
    end else begin
      m_acc[ch] = m_acc[ch] + sd;
    end
    lt = m_last[ch] | l;
    if (emit) begin
      x.d = v[DATA_W-1:0];
      x.u = CH_W'(ch);
      x.l = lt;
      sb.push_back(x);
      m_last[ch] = 0;
    end else begin
      m_last[ch] = lt;
    end
    m_cnt[ch] = (m_cnt[ch] >= re - 1) ? 0 : m_cnt[ch] + 1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input int ch, input logic [DATA_W-1:0] d, input bit l, input bit fl = 0);
    bit rdy;
    int n;
    rdy = 0;
    n = 0;
    s_tuser  = CH_W'(ch);
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    cfg_flush = fl;
    while (!rdy) begin
      @(negedge clk);
      rdy = s_tready;
      @(posedge clk);
      #1;
      n++;
      if (!rdy && n > 50) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    s_tvalid  = 1'b0;
    cfg_flush = 1'b0;
    if (rdy) begin
      if (fl) model_clear();
      else    model(ch, d, l);
    end
  endtask

  task automatic flush();
    cfg_flush = 1'b1;
    @(posedge clk);
    #1;
    cfg_flush = 1'b0;
    model_clear();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Output scoreboard: a beat transfers at the posedge following a negedge
  // that sees valid && ready.
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        check("out_data", 32'(m_tdata), 32'(e.d));
        check("out_user", 32'(m_tuser), 32'(e.u));
        check("out_last", 32'(m_tlast), 32'(e.l));
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      m_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    rst_n = 0; cfg_ratio = 5; cfg_mode = 0; cfg_shift = 0; cfg_flush = 0;
    s_tdata = 0; s_tvalid = 0; s_tuser = 0; s_tlast = 0; m_tready = 1;
    model_clear();
    #12;
    check("rst_tvalid", 32'(m_tvalid), 0);
    check("rst_tdata",  32'(m_tdata), 0);
    check("rst_tuser",  32'(m_tuser), 0);
    check("rst_tlast",  32'(m_tlast), 0);
    check("rst_tready", 32'(s_tready), 1);
    #11 rst_n = 1;
    @(posedge clk); #1;

    // Pick, R=5, ch0, 0..14 with one-cycle latency.
    cfg_ratio = 5; cfg_mode = 0;
    for (int i = 0; i < 15; i++) begin
      send(0, DATA_W'(i), 0);
      @(negedge clk);
      check("t1_sready", 32'(s_tready), 1);
      if (i % 5 == 0) begin
        check("t1_lat_valid", 32'(m_tvalid), 1);
        check("t1_lat_data",  32'(m_tdata), 32'(i));
      end
      @(posedge clk); #1;
    end
    idle(2);

    // Accumulate, R=4, shift=2, ch0/ch1 interleaved.
    flush();
    cfg_ratio = 4; cfg_mode = 1; cfg_shift = 2;
    for (int i = 0; i < 4; i++) begin
      send(0, DATA_W'(4 * (i + 1)), 0);
      send(1, DATA_W'(-4), 0);
    end
    idle(2);

    // Saturation at both rails, R=16, shift=0.
    flush();
    cfg_ratio = 16; cfg_shift = 0;
    for (int i = 0; i < 16; i++) send(4, 24'h7FFFFF, 0);
    for (int i = 0; i < 16; i++) send(4, 24'h800000, 0);
    idle(2);

    // Output stall holds the beat and blocks the input.
    flush();
    cfg_ratio = 1; cfg_mode = 0;
    m_tready = 0;
    send(3, 24'h0ABCDE, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_sready", 32'(s_tready), 0);
      check("stall_valid",  32'(m_tvalid), 1);
      check("stall_data",   32'(m_tdata), 32'h0ABCDE);
      check("stall_user",   32'(m_tuser), 3);
      check("stall_last",   32'(m_tlast), 1);
    end
    @(posedge clk); #1;
    m_tready = 1;
    idle(2);

    // Sticky tlast, R=3, ch2, tlast on 2nd beat.
    flush();
    cfg_ratio = 3; cfg_mode = 0;
    for (int i = 0; i < 7; i++) send(2, DATA_W'(100 + i), (i == 1));
    idle(2);

    // Flush mid-group, then a full group of ones.
    flush();
    cfg_ratio = 4; cfg_mode = 1; cfg_shift = 0;
    send(0, 7, 0);
    send(0, 7, 0);
    flush();
    for (int i = 0; i < 4; i++) send(0, 1, 0);
    idle(2);

    // Flush in the same cycle as an emitting accept discards that beat.
    cfg_ratio = 1; cfg_mode = 0;
    send(0, 99, 0, 1);
    @(negedge clk);
    check("flush_no_out", 32'(m_tvalid), 0);
    @(posedge clk); #1;
    send(0, 5, 0);
    idle(2);

    // Ratio 0 behaves as 1; ratio above 16 clamps to 16.
    cfg_ratio = 0; cfg_mode = 0;
    for (int i = 0; i < 3; i++) send(5, DATA_W'(20 + i), 0);
    flush();
    cfg_ratio = 31; cfg_mode = 1; cfg_shift = 4;
    for (int i = 0; i < 17; i++) send(6, 1000, 0);
    idle(2);

    // Random interleave with random back-pressure.
    flush();
    cfg_ratio = 3; cfg_mode = 1; cfg_shift = 1;
    rnd_rdy = 1;
    for (int i = 0; i < 150; i++)
      send(int'($urandom_range(0, 7)), DATA_W'($urandom), 1'($urandom_range(0, 1)));
    rnd_rdy = 0;
    @(posedge clk); #2;
    m_tready = 1;
    idle(4);
    flush();

    // Reset while an output is pending drops it without a clock edge.
    cfg_ratio = 1; cfg_mode = 0;
    m_tready = 0;
    send(3, 42, 0);
    #2;
    rst_n = 0;
    #1;
    check("rst_drop_valid", 32'(m_tvalid), 0);
    check("rst_drop_data",  32'(m_tdata), 0);
    sb.delete();
    model_clear();
    #10 rst_n = 1;
    m_tready = 1;
    @(posedge clk); #1;
    send(7, 77, 1);
    idle(3);

    check("sb_drain", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    check("global_timeout", 0, 1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end

endmodule
